// File: rtl/top_mul_pipe_pkg.sv
// Shared types and helpers for the pipelined signed multiply/accumulate block.
// MUL_PIPE_SAT_EN: when defined, fit() saturates instead of wrapping.
package top_mul_pipe_pkg;

   // Widest intermediate value any fit() call handles.
   localparam int MAX_W = 64;

   // Side-band tag that travels with every beat through the pipeline.
   typedef struct packed {
      logic valid;
      logic acc_en;
      logic acc_last;
   } beat_tag_t;

   // Full-precision product width for signed operands.
   function automatic int prod_w(input int a_w, input int b_w);
      return a_w + b_w;
   endfunction

   // Narrow a sign-extended value to w bits, returned sign-extended to MAX_W.
   // Callers size-cast the result down to w bits.
   function automatic logic signed [MAX_W-1:0] fit(input logic signed [MAX_W-1:0] x,
                                                   input int w);
`ifdef MUL_PIPE_SAT_EN
      logic signed [MAX_W-1:0] hi;
      logic signed [MAX_W-1:0] lo;
      hi = (MAX_W'(1) <<< (w - 1)) - MAX_W'(1);
      lo = ~hi;
      if (x > hi)
         return hi;
      else if (x < lo)
         return lo;
      else
         return x;
`else
      return (x <<< (MAX_W - w)) >>> (MAX_W - w);
`endif
   endfunction

endpackage

// File: rtl/top_mul_pipe_acc_if.sv
// Valid/ready bus of the pipelined multiplier: input beat channel and result channel.
// master = upstream/downstream side, slave = the multiplier.
interface top_mul_pipe_acc_if #(
   parameter int din0_WIDTH = 14,
   parameter int din1_WIDTH = 12,
   parameter int dout_WIDTH = 26
);
   logic                         in_valid;
   logic                         in_ready;
   logic signed [din0_WIDTH-1:0] din0;
   logic signed [din1_WIDTH-1:0] din1;
   logic                         acc_en;
   logic                         acc_last;
   logic                         out_valid;
   logic                         out_ready;
   logic signed [dout_WIDTH-1:0] dout;

   modport master (
      output in_valid, din0, din1, acc_en, acc_last, out_ready,
      input  in_ready, out_valid, dout
   );

   modport slave (
      input  in_valid, din0, din1, acc_en, acc_last, out_ready,
      output in_ready, out_valid, dout
   );
endinterface

// File: rtl/top_mul_acc_stage.sv
// Output register of the multiplier pipeline: plain results, accumulator for dot products.
// MUL_PIPE_SAT_EN (via fit()): saturating accumulator and output instead of wrap.
module top_mul_acc_stage
   import top_mul_pipe_pkg::*;
#(
   parameter int PROD_W     = 26,
   parameter int ACC_WIDTH  = 32,
   parameter int dout_WIDTH = 26
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         advance,
   input  logic signed [PROD_W-1:0]     prod_i,
   input  beat_tag_t                    tag_i,
   output logic                         out_valid_o,
   output logic signed [dout_WIDTH-1:0] dout_o
);
   localparam int SUM_W = ACC_WIDTH + 1;

   logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, acc_sum;
   logic signed [SUM_W-1:0]      sum_raw;
   logic signed [dout_WIDTH-1:0] dout_q, dout_d, prod_fit, sum_fit;
   logic                         out_valid_q, out_valid_d;

   // Arithmetic: running sum (one guard bit so saturation sees the true overflow) and fitted results.
   always_comb begin
      sum_raw  = SUM_W'(acc_q) + SUM_W'(prod_i);
      acc_sum  = ACC_WIDTH'(fit(MAX_W'(sum_raw), ACC_WIDTH));
      prod_fit = dout_WIDTH'(fit(MAX_W'(prod_i), dout_WIDTH));
      sum_fit  = dout_WIDTH'(fit(MAX_W'(acc_sum), dout_WIDTH));
   end

   // Next state: only an advancing pipeline changes anything here.
   always_comb begin
      acc_d       = acc_q;
      dout_d      = dout_q;
      out_valid_d = out_valid_q;
      if (advance) begin
         if (!tag_i.valid) begin
            out_valid_d = 1'b0;
         end else if (!tag_i.acc_en) begin
            dout_d      = prod_fit;
            out_valid_d = 1'b1;
         end else if (!tag_i.acc_last) begin
            acc_d       = acc_sum;
            out_valid_d = 1'b0;
         end else begin
            dout_d      = sum_fit;
            out_valid_d = 1'b1;
            acc_d       = '0;
         end
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q       <= '0;
         dout_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         dout_q      <= dout_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign dout_o      = dout_q;

endmodule

// File: rtl/top_mul_pipe_acc.sv
// Pipelined signed multiplier with valid/ready flow control and per-beat accumulate.
// NUM_STAGE-1 product registers followed by one output/accumulator stage; global stall.
// MUL_PIPE_SAT_EN: when defined, results and accumulator saturate instead of wrapping.
module top_mul_pipe_acc
   import top_mul_pipe_pkg::*;
#(
   parameter int ID         = 1,
   parameter int NUM_STAGE  = 2,
   parameter int din0_WIDTH = 14,
   parameter int din1_WIDTH = 12,
   parameter int dout_WIDTH = 26,
   parameter int ACC_WIDTH  = 32
) (
   input logic               clk,
   input logic               reset,
   input logic               ce,
   top_mul_pipe_acc_if.slave bus
);
   localparam int PROD_W = prod_w(din0_WIDTH, din1_WIDTH);
   localparam int NREG   = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;

   logic                     advance;
   logic                     out_valid;
   logic signed [PROD_W-1:0] entry_prod, stage_prod;
   beat_tag_t                entry_tag, stage_tag;
   logic signed [PROD_W-1:0] prod_q [NREG];
   logic signed [PROD_W-1:0] prod_d [NREG];
   beat_tag_t                tag_q  [NREG];
   beat_tag_t                tag_d  [NREG];

   if (NUM_STAGE < 1 || ACC_WIDTH < PROD_W || ID < 0) begin : g_cfg_check
      $error("top_mul_pipe_acc: illegal parameter set");
   end

   assign advance      = ce & (~out_valid | bus.out_ready);
   assign bus.in_ready = advance & ~reset;
   assign bus.out_valid = out_valid;

   // Entry: full-precision product and beat tag; acc_last only means something inside an accumulation.
   always_comb begin
      entry_prod = bus.din0 * bus.din1;
      entry_tag  = '{valid: bus.in_valid, acc_en: bus.acc_en,
                     acc_last: bus.acc_en & bus.acc_last};
   end

   for (genvar g = 0; g < NUM_STAGE - 1; g++) begin : g_pipe
      if (g == 0) begin : g_head
         assign prod_d[g] = entry_prod;
         assign tag_d[g]  = entry_tag;
      end else begin : g_body
         assign prod_d[g] = prod_q[g-1];
         assign tag_d[g]  = tag_q[g-1];
      end

      // Product stage: shifts on advance, reset empties it.
      always_ff @(posedge clk) begin
         if (reset) begin
            tag_q[g] <= '0;
         end else if (advance) begin
            tag_q[g]  <= tag_d[g];
            prod_q[g] <= prod_d[g];
         end
      end
   end

   if (NUM_STAGE > 1) begin : g_tail
      assign stage_prod = prod_q[NUM_STAGE-2];
      assign stage_tag  = tag_q[NUM_STAGE-2];
   end else begin : g_direct
      assign stage_prod = entry_prod;
      assign stage_tag  = entry_tag;
   end

   top_mul_acc_stage #(
      .PROD_W     (PROD_W),
      .ACC_WIDTH  (ACC_WIDTH),
      .dout_WIDTH (dout_WIDTH)
   ) u_acc_stage (
      .clk         (clk),
      .reset       (reset),
      .advance     (advance),
      .prod_i      (stage_prod),
      .tag_i       (stage_tag),
      .out_valid_o (out_valid),
      .dout_o      (bus.dout)
   );

endmodule

// File: tb/tb_top_mul_pipe_acc.sv
// Directed bench for top_mul_pipe_acc (4x4 operands, 8-bit result, 12-bit accumulator, 3 stages)
// plus a 4-bit-result instance for overflow behaviour. MUL_PIPE_SAT_EN selects the saturating expectations.
module tb_top_mul_pipe_acc;

   logic clk = 1'b0;
   logic reset;
   logic ce;

   always #5 clk = ~clk;

   top_mul_pipe_acc_if #(.din0_WIDTH(4), .din1_WIDTH(4), .dout_WIDTH(8)) bus ();
   top_mul_pipe_acc_if #(.din0_WIDTH(4), .din1_WIDTH(4), .dout_WIDTH(4)) obus ();

   top_mul_pipe_acc #(
      .ID(1), .NUM_STAGE(3), .din0_WIDTH(4), .din1_WIDTH(4), .dout_WIDTH(8), .ACC_WIDTH(12)
   ) dut (
      .clk(clk), .reset(reset), .ce(ce), .bus(bus)
   );

   top_mul_pipe_acc #(
      .ID(2), .NUM_STAGE(3), .din0_WIDTH(4), .din1_WIDTH(4), .dout_WIDTH(4), .ACC_WIDTH(12)
   ) dut_ovf (
      .clk(clk), .reset(reset), .ce(ce), .bus(obus)
   );

`ifdef MUL_PIPE_SAT_EN
   localparam logic [7:0] OVF_POS = 8'h07;
`else
   localparam logic [7:0] OVF_POS = 8'h00;
`endif
   localparam logic [7:0] OVF_NEG = 8'h08;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] q_main [$];
   logic [7:0] exp_q  [$];

   int sa [8] = '{1, 2, -4, 7, -8, 3, 0, -1};
   int sb [8] = '{1, -3, -4, 7, 7, -2, 5, -1};
   logic [7:0] sexp [8] = '{8'h01, 8'hFA, 8'h10, 8'h31, 8'hC8, 8'hFA, 8'h00, 8'h01};

   // Record each result in the cycle it is handed downstream.
   always @(negedge clk) begin
      if (!reset && ce && bus.out_valid && bus.out_ready)
         q_main.push_back(bus.dout);
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input int a, input int b, input logic en, input logic last);
      bus.in_valid = v;
      bus.din0     = 4'(a);
      bus.din1     = 4'(b);
      bus.acc_en   = en;
      bus.acc_last = last;
   endtask

   task automatic wait_q(input int n);
      for (int c = 0; c < 20 && q_main.size() < n; c++) cyc();
      repeat (3) cyc();
   endtask

   task automatic chk_q(input string tag);
      chk({tag, ".count"}, 8'(q_main.size()), 8'(exp_q.size()));
      foreach (exp_q[i])
         chk($sformatf("%s[%0d]", tag, i), (i < q_main.size()) ? q_main[i] : 8'hxx, exp_q[i]);
      q_main.delete();
      exp_q.delete();
   endtask

   initial begin
      reset = 1'b1;
      ce    = 1'b1;
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      bus.out_ready  = 1'b1;
      obus.in_valid  = 1'b0;
      obus.din0      = '0;
      obus.din1      = '0;
      obus.acc_en    = 1'b0;
      obus.acc_last  = 1'b0;
      obus.out_ready = 1'b1;

      // Reset
      cyc();
      chk("rst.in_ready", {7'b0, bus.in_ready}, 8'h00);
      chk("rst.out_valid", {7'b0, bus.out_valid}, 8'h00);
      chk("rst.dout", bus.dout, 8'h00);
      reset = 1'b0;
      cyc();

      // Plain product and overflow instance
      drive(1'b1, -3, 5, 1'b0, 1'b0);
      obus.in_valid = 1'b1;
      obus.din0 = 4'sd0 - 4'sd8;
      obus.din1 = 4'sd0 - 4'sd8;
      #1;
      chk("plain.in_ready", {7'b0, bus.in_ready}, 8'h01);
      cyc();
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      obus.din1 = 4'sd7;
      chk("plain.lat1", {7'b0, bus.out_valid}, 8'h00);
      cyc();
      obus.in_valid = 1'b0;
      chk("plain.lat2", {7'b0, bus.out_valid}, 8'h00);
      cyc();
      chk("plain.out_valid", {7'b0, bus.out_valid}, 8'h01);
      chk("plain.dout", bus.dout, 8'hF1);
      chk("ovf.out_valid", {7'b0, obus.out_valid}, 8'h01);
      chk("ovf.pos", {4'h0, obus.dout}, OVF_POS);
      cyc();
      chk("plain.bubble", {7'b0, bus.out_valid}, 8'h00);
      chk("ovf.neg", {4'h0, obus.dout}, OVF_NEG);
      repeat (2) cyc();
      q_main.delete();

      // Streaming, back to back
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, sa[i], sb[i], 1'b0, 1'b0);
         #1;
         chk($sformatf("stream.in_ready[%0d]", i), {7'b0, bus.in_ready}, 8'h01);
         cyc();
      end
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      wait_q(8);
      foreach (sexp[i]) exp_q.push_back(sexp[i]);
      chk_q("stream");

      // Backpressure with a full pipeline, then a ce stall
      bus.out_ready = 1'b0;
      drive(1'b1, 1, 2, 1'b0, 1'b0);
      #1;
      chk("bp.in_ready0", {7'b0, bus.in_ready}, 8'h01);
      cyc();
      drive(1'b1, 2, 2, 1'b0, 1'b0);
      cyc();
      drive(1'b1, 3, 2, 1'b0, 1'b0);
      cyc();
      drive(1'b1, 4, 2, 1'b0, 1'b0);
      #1;
      chk("bp.in_ready_full", {7'b0, bus.in_ready}, 8'h00);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk($sformatf("bp.hold_valid[%0d]", i), {7'b0, bus.out_valid}, 8'h01);
         chk($sformatf("bp.hold_dout[%0d]", i), bus.dout, 8'h02);
         chk($sformatf("bp.hold_ready[%0d]", i), {7'b0, bus.in_ready}, 8'h00);
      end
      ce = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      chk("ce.in_ready", {7'b0, bus.in_ready}, 8'h00);
      cyc();
      chk("ce.out_valid", {7'b0, bus.out_valid}, 8'h01);
      chk("ce.dout", bus.dout, 8'h02);
      ce = 1'b1;
      #1;
      chk("bp.release", {7'b0, bus.in_ready}, 8'h01);
      cyc();
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      wait_q(4);
      exp_q = '{8'h02, 8'h04, 8'h06, 8'h08};
      chk_q("bp");

      // Dot products with an interleaved plain beat; second sum proves the clear
      drive(1'b1, 2, 3, 1'b1, 1'b0);  cyc();
      drive(1'b1, -4, 5, 1'b1, 1'b0); cyc();
      drive(1'b1, 3, 3, 1'b0, 1'b0);  cyc();
      drive(1'b1, 7, 7, 1'b1, 1'b1);  cyc();
      drive(1'b1, 1, 1, 1'b1, 1'b0);  cyc();
      drive(1'b1, 2, 2, 1'b1, 1'b1);  cyc();
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      wait_q(3);
      exp_q = '{8'h09, 8'h23, 8'h05};
      chk_q("dot");

      // Reset mid-accumulation with beats still in flight
      drive(1'b1, 3, 3, 1'b1, 1'b0); cyc();
      drive(1'b1, 2, 2, 1'b1, 1'b0); cyc();
      drive(1'b1, 5, 1, 1'b0, 1'b0); cyc();
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      reset = 1'b1;
      #1;
      chk("mid.rst_in_ready", {7'b0, bus.in_ready}, 8'h00);
      cyc();
      chk("mid.rst_out_valid", {7'b0, bus.out_valid}, 8'h00);
      chk("mid.rst_dout", bus.dout, 8'h00);
      reset = 1'b0;
      drive(1'b1, 1, 1, 1'b1, 1'b1);
      cyc();
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      wait_q(1);
      exp_q = '{8'h01};
      chk_q("mid");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
